// File: rtl/trig_unit_pkg.sv
// Shared types and sizing for the logic-analyzer trigger unit.
package la_trig_pkg;

    // Number of channel trigger flags ANDed into the trigger condition.
    localparam int NUM_CH     = 5;
    // Width of the post-trigger sample count (trig_pos / trig_cnt).
    localparam int TRIG_POS_W = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRIGGERED = 2'd1,
        DONE      = 2'd2
    } trig_state_t;

endpackage

// File: rtl/trig_unit_if.sv
// Bundle of trigger inputs and status outputs between capture control and the trigger unit.
interface trig_unit_if;
    import la_trig_pkg::*;

    logic [NUM_CH-1:0]     ch_trig;
    logic                  prot_trig;
    logic                  armed;
    logic                  smpl_en;
    logic [TRIG_POS_W-1:0] trig_pos;
    logic                  clr_trig;
    logic                  triggered;
    logic                  capture_done;
    logic [TRIG_POS_W-1:0] trig_cnt;

    // Capture control side: drives trigger flags and commands, observes status.
    modport master (
        output ch_trig, prot_trig, armed, smpl_en, trig_pos, clr_trig,
        input  triggered, capture_done, trig_cnt
    );

    // Trigger unit side.
    modport slave (
        input  ch_trig, prot_trig, armed, smpl_en, trig_pos, clr_trig,
        output triggered, capture_done, trig_cnt
    );

endinterface

// File: rtl/trig_unit_post_cnt.sv
// Post-trigger sample counter: clears on request, counts enabled strobes,
// and flags the strobe that brings the count up to the limit.
module trig_post_cnt
    import la_trig_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [TRIG_POS_W-1:0] i_limit,
    output logic [TRIG_POS_W-1:0] o_cnt,
    output logic                  o_hit
);

    logic [TRIG_POS_W-1:0] r_cnt;
    logic [TRIG_POS_W-1:0] w_last;

    // The final strobe is the one seen while the count sits one below the limit;
    // the owner stops enabling us afterwards, so the count parks at the limit.
    assign w_last = i_limit - TRIG_POS_W'(1);
    assign o_hit  = i_en & (r_cnt == w_last);
    assign o_cnt  = r_cnt;

    // Count register: clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TRIG_POS_W'(1);
        end
    end

endmodule

// File: rtl/trig_unit.sv
// Trigger qualifier and post-trigger sample counter. Combines channel and
// protocol trigger flags while armed, then counts trig_pos samples and
// reports capture_done until the command side clears the unit.
module trig_unit
    import la_trig_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    trig_unit_if.slave bus
);

    trig_state_t           r_state;
    trig_state_t           w_state_next;
    logic                  r_trig_set_q;
    logic [TRIG_POS_W-1:0] r_trig_pos_q;
    logic                  w_load_pos;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_cnt_hit;
    logic [TRIG_POS_W-1:0] w_cnt;

    // Combine stage: all channel flags, the protocol flag and armed must coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_set_q <= 1'b0;
        end else begin
            r_trig_set_q <= bus.armed & bus.prot_trig & (&bus.ch_trig);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; clr_trig overrides any trigger or final sample in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load_pos   = 1'b0;
        w_cnt_clr    = (r_state == IDLE);
        w_cnt_en     = 1'b0;
        if (bus.clr_trig) begin
            w_state_next = IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Later trigger pulses are ignored once we leave IDLE.
                    if (r_trig_set_q) begin
                        w_load_pos   = 1'b1;
                        w_state_next = (bus.trig_pos == '0) ? DONE : TRIGGERED;
                    end
                end
                TRIGGERED: begin
                    // Strobes are only counted from inside TRIGGERED, so a strobe
                    // coinciding with the trigger transition is not counted.
                    w_cnt_en = bus.smpl_en;
                    if (w_cnt_hit) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    w_state_next = DONE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Capture the sample limit at the trigger so later trig_pos changes have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_pos_q <= '0;
        end else if (bus.clr_trig) begin
            r_trig_pos_q <= '0;
        end else if (w_load_pos) begin
            r_trig_pos_q <= bus.trig_pos;
        end
    end

    trig_post_cnt u_post_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (r_trig_pos_q),
        .o_cnt   (w_cnt),
        .o_hit   (w_cnt_hit)
    );

    // Status is decoded straight from registered state and count.
    assign bus.triggered    = (r_state == TRIGGERED) || (r_state == DONE);
    assign bus.capture_done = (r_state == DONE);
    assign bus.trig_cnt     = w_cnt;

endmodule

// File: tb/tb_trig_unit.sv
// Directed bench for trig_unit: reset, triggering, gating, limits and clear behaviour.
module tb_trig_unit;
    import la_trig_pkg::*;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    trig_unit_if bus ();

    trig_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_inputs();
        bus.ch_trig   = '0;
        bus.prot_trig = 1'b0;
        bus.armed     = 1'b0;
        bus.smpl_en   = 1'b0;
        bus.clr_trig  = 1'b0;
    endtask

    // Return the unit to IDLE with the combine stage flushed.
    task automatic clear_all();
        drop_inputs();
        tick();
        bus.clr_trig = 1'b1;
        tick();
        bus.clr_trig = 1'b0;
    endtask

    // Single-cycle trigger pulse; on return the trigger edge (N+2) has just passed.
    task automatic fire(input logic [TRIG_POS_W-1:0] pos);
        bus.ch_trig   = 5'h1F;
        bus.prot_trig = 1'b1;
        bus.armed     = 1'b1;
        bus.trig_pos  = pos;
        tick();
        bus.ch_trig = '0;
        bus.armed   = 1'b0;
        tick();
    endtask

    task automatic strobe();
        bus.smpl_en = 1'b1;
        tick();
        bus.smpl_en = 1'b0;
    endtask

    task automatic test_reset();
        drop_inputs();
        bus.trig_pos = '0;
        rst = 1'b1;
        #12;
        total_cnt++; if (bus.triggered !== 1'b0) $display("FAIL reset_trig got %0b want 0", bus.triggered); else pass_cnt++;
        total_cnt++; if (bus.capture_done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.capture_done); else pass_cnt++;
        total_cnt++; if (bus.trig_cnt !== 9'd0) $display("FAIL reset_cnt got %0d want 0", bus.trig_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        // Mid-count asynchronous reset.
        fire(9'd8);
        strobe(); strobe(); strobe();
        total_cnt++; if (bus.trig_cnt !== 9'd3) $display("FAIL midrst_pre_cnt got %0d want 3", bus.trig_cnt); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.triggered !== 1'b0) $display("FAIL midrst_trig got %0b want 0", bus.triggered); else pass_cnt++;
        total_cnt++; if (bus.trig_cnt !== 9'd0) $display("FAIL midrst_cnt got %0d want 0", bus.trig_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        total_cnt++; if (bus.triggered !== 1'b0 || bus.capture_done !== 1'b0) $display("FAIL midrst_idle got trig=%0b done=%0b want 0/0", bus.triggered, bus.capture_done); else pass_cnt++;
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        clear_all();
        bus.ch_trig   = 5'h1F;
        bus.prot_trig = 1'b1;
        bus.armed     = 1'b1;
        bus.trig_pos  = 9'd4;
        tick();
        total_cnt++; if (bus.triggered !== 1'b0) $display("FAIL basic_n1 got %0b want 0", bus.triggered); else pass_cnt++;
        bus.ch_trig = '0;
        bus.armed   = 1'b0;
        bus.smpl_en = 1'b1;   // coincides with IDLE->TRIGGERED; must not count
        tick();
        bus.smpl_en = 1'b0;
        total_cnt++; if (bus.triggered !== 1'b1) $display("FAIL basic_n2 got %0b want 1", bus.triggered); else pass_cnt++;
        total_cnt++; if (bus.trig_cnt !== 9'd0) $display("FAIL basic_edge_cnt got %0d want 0", bus.trig_cnt); else pass_cnt++;
        strobe(); tick(); strobe(); strobe();
        total_cnt++; if (bus.trig_cnt !== 9'd3 || bus.capture_done !== 1'b0) $display("FAIL basic_3 got cnt=%0d done=%0b want 3/0", bus.trig_cnt, bus.capture_done); else pass_cnt++;
        strobe();
        total_cnt++; if (bus.capture_done !== 1'b1) $display("FAIL basic_done got %0b want 1", bus.capture_done); else pass_cnt++;
        total_cnt++; if (bus.trig_cnt !== 9'd4) $display("FAIL basic_cnt got %0d want 4", bus.trig_cnt); else pass_cnt++;
        strobe(); tick();
        total_cnt++; if (bus.trig_cnt !== 9'd4 || bus.capture_done !== 1'b1 || bus.triggered !== 1'b1) $display("FAIL basic_hold got cnt=%0d done=%0b want 4/1", bus.trig_cnt, bus.capture_done); else pass_cnt++;
        bus.clr_trig = 1'b1;
        tick();
        bus.clr_trig = 1'b0;
        total_cnt++; if (bus.triggered !== 1'b0 || bus.capture_done !== 1'b0 || bus.trig_cnt !== 9'd0) $display("FAIL basic_clr got trig=%0b done=%0b cnt=%0d want 0/0/0", bus.triggered, bus.capture_done, bus.trig_cnt); else pass_cnt++;
        $display("test_basic complete");
    endtask

    task automatic test_gating();
        logic [2:0] seen;
        clear_all();
        bus.trig_pos = 9'd4;
        for (int c = 0; c < 3; c++) begin
            seen = '0;
            bus.ch_trig   = (c == 0) ? 5'h1E : 5'h1F;
            bus.prot_trig = (c == 1) ? 1'b0 : 1'b1;
            bus.armed     = (c == 2) ? 1'b0 : 1'b1;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (bus.triggered !== 1'b0) seen[c] = 1'b1;
            end
            total_cnt++; if (seen[c] !== 1'b0) $display("FAIL gating_case%0d got triggered want 0", c); else pass_cnt++;
        end
        bus.ch_trig   = 5'h1F;
        bus.prot_trig = 1'b1;
        bus.armed     = 1'b1;
        tick();
        total_cnt++; if (bus.triggered !== 1'b0) $display("FAIL gating_n1 got %0b want 0", bus.triggered); else pass_cnt++;
        tick();
        total_cnt++; if (bus.triggered !== 1'b1) $display("FAIL gating_n2 got %0b want 1", bus.triggered); else pass_cnt++;
        $display("test_gating complete");
    endtask

    task automatic test_pos_zero();
        clear_all();
        bus.ch_trig   = 5'h1F;
        bus.prot_trig = 1'b1;
        bus.armed     = 1'b1;
        bus.trig_pos  = 9'd0;
        tick();
        bus.ch_trig = '0;
        total_cnt++; if (bus.capture_done !== 1'b0) $display("FAIL pos0_n1 got %0b want 0", bus.capture_done); else pass_cnt++;
        tick();
        total_cnt++; if (bus.triggered !== 1'b1 || bus.capture_done !== 1'b1) $display("FAIL pos0_n2 got trig=%0b done=%0b want 1/1", bus.triggered, bus.capture_done); else pass_cnt++;
        total_cnt++; if (bus.trig_cnt !== 9'd0) $display("FAIL pos0_cnt got %0d want 0", bus.trig_cnt); else pass_cnt++;
        $display("test_pos_zero complete");
    endtask

    task automatic test_clear_priority();
        logic done_seen;
        clear_all();
        fire(9'd2);
        strobe();
        bus.smpl_en  = 1'b1;
        bus.clr_trig = 1'b1;
        tick();
        bus.smpl_en  = 1'b0;
        bus.clr_trig = 1'b0;
        done_seen = bus.capture_done;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.capture_done !== 1'b0) done_seen = 1'b1;
        end
        total_cnt++; if (done_seen !== 1'b0) $display("FAIL clrpri_done got 1 want 0"); else pass_cnt++;
        total_cnt++; if (bus.triggered !== 1'b0 || bus.trig_cnt !== 9'd0) $display("FAIL clrpri_idle got trig=%0b cnt=%0d want 0/0", bus.triggered, bus.trig_cnt); else pass_cnt++;
        fire(9'd1);
        total_cnt++; if (bus.triggered !== 1'b1 || bus.capture_done !== 1'b0) $display("FAIL clrpri_retrig got trig=%0b done=%0b want 1/0", bus.triggered, bus.capture_done); else pass_cnt++;
        strobe();
        total_cnt++; if (bus.capture_done !== 1'b1 || bus.trig_cnt !== 9'd1) $display("FAIL clrpri_redone got done=%0b cnt=%0d want 1/1", bus.capture_done, bus.trig_cnt); else pass_cnt++;
        $display("test_clear_priority complete");
    endtask

    task automatic test_ignore_changes();
        clear_all();
        fire(9'd4);
        bus.trig_pos = 9'd10;
        strobe(); strobe();
        bus.ch_trig   = 5'h1F;
        bus.prot_trig = 1'b1;
        bus.armed     = 1'b1;
        tick();
        bus.ch_trig = '0;
        bus.armed   = 1'b0;
        tick(); tick();
        total_cnt++; if (bus.trig_cnt !== 9'd2 || bus.triggered !== 1'b1) $display("FAIL ignore_retrig got cnt=%0d trig=%0b want 2/1", bus.trig_cnt, bus.triggered); else pass_cnt++;
        strobe();
        total_cnt++; if (bus.capture_done !== 1'b0) $display("FAIL ignore_early got %0b want 0", bus.capture_done); else pass_cnt++;
        strobe();
        total_cnt++; if (bus.capture_done !== 1'b1 || bus.trig_cnt !== 9'd4) $display("FAIL ignore_done got done=%0b cnt=%0d want 1/4", bus.capture_done, bus.trig_cnt); else pass_cnt++;
        $display("test_ignore_changes complete");
    endtask

    task automatic test_max_pos();
        clear_all();
        fire(9'd511);
        for (int k = 0; k < 510; k++) strobe();
        total_cnt++; if (bus.trig_cnt !== 9'd510 || bus.capture_done !== 1'b0) $display("FAIL max_510 got cnt=%0d done=%0b want 510/0", bus.trig_cnt, bus.capture_done); else pass_cnt++;
        strobe();
        total_cnt++; if (bus.trig_cnt !== 9'd511 || bus.capture_done !== 1'b1) $display("FAIL max_511 got cnt=%0d done=%0b want 511/1", bus.trig_cnt, bus.capture_done); else pass_cnt++;
        strobe(); strobe();
        total_cnt++; if (bus.trig_cnt !== 9'd511) $display("FAIL max_nowrap got %0d want 511", bus.trig_cnt); else pass_cnt++;
        $display("test_max_pos complete");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_gating();
        test_pos_zero();
        test_clear_priority();
        test_ignore_changes();
        test_max_pos();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
